mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the processor's I/O port (address window 0x00007ff0–0x00007fff).
- Consumes IOWriteData, IOAddr and IOWriteEn, and drives IOReadData back to the core.
- Buffers bytes written by SW in a small FIFO and serialises them on TXD (8N1).
- Software polls STATUS before writing.

---
 rtl/mmio_uart_pkg.sv | 25 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 146 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared definitions for the memory-mapped UART blocks.
// Contents: register offsets within the I/O window, the TX FSM state encoding
// and the bit positions of the STATUS register.
// Build option: MMIO_UART_PARITY_EN adds the PARITY state to the encoding.
package mmio_uart_pkg;
    localparam logic [3:0] TXDATA_OFS  = 4'h0;
    localparam logic [3:0] STATUS_OFS  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFS = 4'h8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MMIO_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;
endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock circular FIFO, reusable by the UART TX and RX blocks.
// Ports:
//   CLK    in   system clock
//   RESET  in   synchronous active-low reset (empties the FIFO)
//   push   in   write din; ignored while full
//   din    in   WIDTH-bit write data
//   pop    in   advance the read pointer; ignored while empty
//   dout   out  WIDTH-bit head entry (valid while !empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge CLK)
        if (do_push) mem[wptr] <= din;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a byte FIFO (8N1, or 8E1).
// Ports:
//   CLK          in   system clock
//   RESET        in   synchronous active-low reset
//   IOWriteData  in   32-bit store data from the core
//   IOAddr       in   byte offset within the I/O window (bits [1:0] ignored)
//   IOWriteEn    in   store to the I/O window this cycle
//   IOReadData   out  combinational load data for IOAddr
//   TXD          out  registered serial output, idle high
// Registers: 0x0 TXDATA (W), 0x4 STATUS (R, write clears ovf), 0x8 BAUDDIV (R/W).
// Build option: define MMIO_UART_PARITY_EN to append an even parity bit.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd86
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOWriteData,
    input  logic [3:0]  IOAddr,
    input  logic        IOWriteEn,
    output logic [31:0] IOReadData,
    output logic        TXD
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef MMIO_UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    state_t        state;
    logic [15:0]   bauddiv, divlat, divcnt;
    logic [7:0]    shift, dout;
    logic [2:0]    bitcnt;
    logic          ovf, full, empty, push, pop, bit_end;
    logic          wr_tx, wr_st, wr_bd;
    logic [3:0]    sel;
    logic [CW-1:0] count;
    logic [31:0]   status;
    logic          unused;
`ifdef MMIO_UART_PARITY_EN
    logic          par;
`endif

    assign unused  = ^{IOWriteData[31:16], IOAddr[1:0]};
    assign sel     = {IOAddr[3:2], 2'b00};
    assign wr_tx   = IOWriteEn && sel == TXDATA_OFS;
    assign wr_st   = IOWriteEn && sel == STATUS_OFS;
    assign wr_bd   = IOWriteEn && sel == BAUDDIV_OFS;
    assign push    = wr_tx && !full;
    assign pop     = state == IDLE && !empty;
    assign bit_end = divcnt == divlat;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .din   (IOWriteData[7:0]),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        status            = '0;
        status[15:8]      = 8'(count);
        status[ST_PAR]    = PAR_EN;
        status[ST_OVF]    = ovf;
        status[ST_BUSY]   = state != IDLE;
        status[ST_EMPTY]  = empty;
        status[ST_FULL]   = full;
        IOReadData        = sel == STATUS_OFS  ? status :
                            sel == BAUDDIV_OFS ? {16'b0, bauddiv} : 32'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bauddiv <= DEFAULT_DIV;
            ovf     <= 1'b0;
        end else begin
            if (wr_bd) bauddiv <= IOWriteData[15:0];
            ovf <= wr_st ? 1'b0 : (wr_tx && full) ? 1'b1 : ovf;
        end
    end

    // TXD is driven from the pre-edge state, so the line trails the FSM by one cycle
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            TXD    <= 1'b1;
            divcnt <= '0;
            divlat <= '0;
            bitcnt <= '0;
            shift  <= '0;
`ifdef MMIO_UART_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
`ifdef MMIO_UART_PARITY_EN
            TXD <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
`else
            TXD <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
            if (state == IDLE) begin
                if (!empty) begin
                    shift  <= dout;
                    state  <= START;
                    divcnt <= '0;
                    divlat <= bauddiv;
`ifdef MMIO_UART_PARITY_EN
                    par    <= ^dout;
`endif
                end
            end else if (bit_end) begin
                // every bit period re-samples BAUDDIV
                divcnt <= '0;
                divlat <= bauddiv;
                case (state)
                    START: begin
                        state  <= DATA;
                        bitcnt <= '0;
                    end
                    DATA: begin
                        shift  <= shift >> 1;
                        bitcnt <= bitcnt + 1'b1;
`ifdef MMIO_UART_PARITY_EN
                        if (bitcnt == 3'd7) state <= PARITY;
`else
                        if (bitcnt == 3'd7) state <= STOP;
`endif
                    end
`ifdef MMIO_UART_PARITY_EN
                    PARITY: state <= STOP;
`endif
                    default: state <= IDLE;
                endcase
            end else begin
                divcnt <= divcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx; frames are queued at issue time
// and a TXD monitor checks every bit level and duration as the frame appears.
module tb_mmio_uart_tx;
    import mmio_uart_pkg::*;

`ifdef MMIO_UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 11 : 10;
    localparam logic [31:0] PB = PAR ? 32'h10 : 32'h0;

    typedef struct {
        logic [7:0] data;
        int         dur[11];
        int         gap;
    } frame_t;

    logic        CLK = 1'b0, RESET = 1'b0, IOWriteEn = 1'b0, TXD;
    logic [31:0] IOWriteData = '0, IOReadData;
    logic [3:0]  IOAddr = '0;

    frame_t exp_q[$];
    frame_t mf;
    int  checks = 0, errors = 0, cyc = 0, last_end = 0;
    bit  mon_en = 1'b0, mon_busy = 1'b0;

    mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd86)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IOWriteData (IOWriteData),
        .IOAddr      (IOAddr),
        .IOWriteEn   (IOWriteEn),
        .IOReadData  (IOReadData),
        .TXD         (TXD)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic frame_t mk(input logic [7:0] d, input int p);
        frame_t f;
        f.data = d;
        f.gap  = -1;
        for (int i = 0; i < 11; i++) f.dur[i] = p;
        return f;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        IOAddr = a;
        IOWriteData = d;
        IOWriteEn = 1'b1;
        @(posedge CLK);
        #1;
        IOWriteEn = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] req, input string name);
        IOAddr = a;
        #1;
        checks++;
        if (IOReadData !== req) begin
            errors++;
            $display("FAIL %s: read %h, required %h", name, IOReadData, req);
        end
    endtask

    task automatic chk_txd(input logic req, input string name);
        checks++;
        if (TXD !== req) begin
            errors++;
            $display("FAIL %s: TXD %b, required %b", name, TXD, req);
        end
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < lim) begin
            @(posedge CLK);
            n++;
        end
        #1;
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL drain: %0d frames still pending after %0d cycles, required 0", exp_q.size(), lim);
        end
    endtask

    // TXD monitor: a low level while idle starts the frame at the queue head
    initial begin
        logic lvl;
        int   bad;
        forever begin
            @(negedge CLK);
            if (mon_en && TXD === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: TXD 0 at cycle %0d, required idle 1", cyc);
                end else begin
                    mon_busy = 1'b1;
                    mf = exp_q.pop_front();
                    if (mf.gap >= 0) begin
                        checks++;
                        if (cyc - last_end - 1 != mf.gap) begin
                            errors++;
                            $display("FAIL idle_gap byte %h: %0d idle cycles, required %0d", mf.data, cyc - last_end - 1, mf.gap);
                        end
                    end
                    for (int i = 0; i < NB; i++) begin
                        lvl = i == 0 ? 1'b0 : i <= 8 ? mf.data[i-1] : (PAR && i == 9) ? ^mf.data : 1'b1;
                        bad = 0;
                        for (int c = 0; c < mf.dur[i]; c++) begin
                            if (i != 0 || c != 0) @(negedge CLK);
                            if (TXD !== lvl) bad++;
                        end
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL frame byte %h bit %0d: %0d of %0d samples wrong, required level %b", mf.data, i, bad, mf.dur[i], lvl);
                        end
                    end
                    last_end = cyc;
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        frame_t f;
        // reset
        repeat (2) @(posedge CLK);
        #1;
        chk_txd(1'b1, "reset_txd");
        rd(4'h4, 32'h2 | PB, "reset_status");
        rd(4'h8, 32'd86, "reset_bauddiv");
        RESET = 1'b1;
        mon_en = 1'b1;
        @(posedge CLK);
        #1;

        // 0xA5 at BAUDDIV=3, plus push-to-start latency
        wr(4'h8, 32'd3);
        rd(4'h8, 32'd3, "bauddiv_rw");
        exp_q.push_back(mk(8'hA5, 4));
        wr(4'h0, 32'hA5);
        @(posedge CLK);
        #1;
        chk_txd(1'b1, "latency_n1");
        @(posedge CLK);
        #1;
        chk_txd(1'b0, "latency_n2");
        drain(200);

        // fill past depth, overflow flag
        wr(4'h8, 32'd100);
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back(mk(8'(k * 8'h11), 101));
            wr(4'h0, 32'(k * 8'h11));
        end
        rd(4'h4, 32'h805 | PB, "full_no_ovf");
        wr(4'h0, 32'hEE);
        rd(4'h4, 32'h80D | PB, "ovf_set");
        wr(4'h4, 32'h0);
        rd(4'h4, 32'h805 | PB, "ovf_cleared");
        drain(12000);
        rd(4'h4, 32'h2 | PB, "idle_after_drain");

        // back-to-back at BAUDDIV=0
        wr(4'h8, 32'd0);
        exp_q.push_back(mk(8'h00, 1));
        f = mk(8'hFF, 1);
        f.gap = 1;
        exp_q.push_back(f);
        wr(4'h0, 32'h00);
        wr(4'h0, 32'hFF);
        drain(100);

        // BAUDDIV 5 -> 1 written during data bit 3
        wr(4'h8, 32'd5);
        f = mk(8'h3C, 6);
        for (int i = 5; i < 11; i++) f.dur[i] = 2;
        exp_q.push_back(f);
        wr(4'h0, 32'h3C);
        repeat (27) @(posedge CLK);
        #1;
        wr(4'h8, 32'd1);
        drain(200);

        // reset during data bit 2 with three bytes queued
        mon_en = 1'b0;
        wr(4'h8, 32'd5);
        wr(4'h0, 32'h00);
        wr(4'h0, 32'h00);
        wr(4'h0, 32'h00);
        repeat (18) @(posedge CLK);
        #1;
        chk_txd(1'b0, "mid_frame_low");
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk_txd(1'b1, "abort_txd");
        rd(4'h4, 32'h2 | PB, "abort_status");
        RESET = 1'b1;
        begin
            int lows = 0;
            repeat (200) begin
                @(negedge CLK);
                if (TXD !== 1'b1) lows++;
            end
            checks++;
            if (lows != 0) begin
                errors++;
                $display("FAIL no_frame_after_reset: %0d low samples, required 0", lows);
            end
        end
        #1;
        rd(4'h8, 32'd86, "bauddiv_after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
